// File: rtl/bcd_pkg.sv
// rtl/bcd_pkg.sv - shared types and constants for the binary-to-BCD stream converter
package bcd_pkg;

  // Converter control states; any other encoding recovers to S_IDLE.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CONV = 2'd1,
    S_DONE = 2'd2
  } state_t;

  typedef logic [3:0] bcd_digit_t;

  // A digit of 5 or more would become >= 10 after the next doubling,
  // so it is pre-corrected by 3 before the shift.
  localparam bcd_digit_t ADD3_THRESH = 4'd5;
  localparam bcd_digit_t ADD3_VAL    = 4'd3;

  // Double-dabble correction for one digit; legal inputs 0..9 never wrap.
  function automatic bcd_digit_t add3(input bcd_digit_t d);
    return (d >= ADD3_THRESH) ? bcd_digit_t'(d + ADD3_VAL) : d;
  endfunction

endpackage

// File: rtl/bin2bcd_stream_if.sv
// rtl/bin2bcd_stream_if.sv - input/output handshake bundle of the BCD converter
interface bin2bcd_stream_if #(
  parameter int IN_W   = 32,
  parameter int DIGITS = 10
);
  localparam int ND_W = $clog2(DIGITS + 1);

  logic                  in_valid;
  logic                  in_ready;
  logic [IN_W-1:0]       in_data;
  logic                  in_signed;
  logic                  out_valid;
  logic                  out_ready;
  logic [4*DIGITS-1:0]   out_bcd;
  logic                  out_neg;
  logic [ND_W-1:0]       out_ndigits;
  logic                  out_ovf;

  // Producer of words and consumer of results.
  modport master (
    output in_valid, in_data, in_signed, out_ready,
    input  in_ready, out_valid, out_bcd, out_neg, out_ndigits, out_ovf
  );

  // The converter itself.
  modport slave (
    input  in_valid, in_data, in_signed, out_ready,
    output in_ready, out_valid, out_bcd, out_neg, out_ndigits, out_ovf
  );

endinterface

// File: rtl/bcd_digit_adj.sv
// rtl/bcd_digit_adj.sv - combinational +3 correction of a single BCD digit
module bcd_digit_adj
  import bcd_pkg::*;
(
  input  bcd_digit_t din,
  output bcd_digit_t dout
);

  assign dout = add3(din);

endmodule

// File: rtl/bin2bcd_stream.sv
// rtl/bin2bcd_stream.sv - iterative shift/add-3 binary-to-BCD converter with handshakes
module bin2bcd_stream
  import bcd_pkg::*;
#(
  parameter int IN_W      = 32,
  parameter int DIGITS    = 10,
  parameter int SIGNED_EN = 1,
  parameter int CNT_W     = $clog2(IN_W + 1),
  parameter int ND_W      = $clog2(DIGITS + 1)
) (
  input logic              clk,
  input logic              rst_n,
  bin2bcd_stream_if.slave  bus
);

  state_t               state;
  state_t               state_nxt;
  logic                 in_ready_c;
  logic                 out_valid_c;
  logic                 accept;
  logic                 in_neg;
  logic [IN_W-1:0]      in_mag;
  logic [IN_W-1:0]      mag;
  logic [4*DIGITS-1:0]  acc;
  logic [4*DIGITS-1:0]  adj;
  logic                 neg;
  logic                 ovf;
  logic [CNT_W-1:0]     cnt;
  logic [ND_W-1:0]      ndigits;

  assign accept = bus.in_valid && in_ready_c;

  // Sign is only honoured when the build enables it and the word asks for it.
  assign in_neg = (SIGNED_EN != 0) && bus.in_signed && bus.in_data[IN_W-1];

  // Two's-complement magnitude; the most negative value maps to 2^(IN_W-1)
  // naturally because the magnitude is treated as unsigned.
  assign in_mag = in_neg ? (~bus.in_data + IN_W'(1)) : bus.in_data;

  // One correction cell per digit, all applied before the shift of the cycle.
  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .din  (acc[4*g +: 4]),
      .dout (adj[4*g +: 4])
    );
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and handshake outputs; the converter never accepts while busy
  // or while a result is still waiting to be taken.
  always_comb begin
    state_nxt   = state;
    in_ready_c  = 1'b0;
    out_valid_c = 1'b0;
    case (state)
      S_IDLE: begin
        in_ready_c = 1'b1;
        if (bus.in_valid) begin
          state_nxt = S_CONV;
        end
      end
      S_CONV: begin
        if (cnt == CNT_W'(1)) begin
          state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        out_valid_c = 1'b1;
        if (bus.out_ready) begin
          state_nxt = S_IDLE;
        end
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Datapath: load on accept, then one fused add-3/shift per cycle; the
  // result registers simply hold in S_DONE so backpressure needs no extra copy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mag <= '0;
      acc <= '0;
      neg <= 1'b0;
      ovf <= 1'b0;
      cnt <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            mag <= in_mag;
            neg <= in_neg;
            acc <= '0;
            ovf <= 1'b0;
            cnt <= CNT_W'(IN_W);
          end
        end
        S_CONV: begin
          acc <= {adj[4*DIGITS-2:0], mag[IN_W-1]};
          mag <= {mag[IN_W-2:0], 1'b0};
          cnt <= cnt - CNT_W'(1);
          // A bit leaving the top digit means the value needs more digits.
          if (adj[4*DIGITS-1]) begin
            ovf <= 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Significant-digit count: highest nonzero digit + 1, at least 1; an
  // overflowed result always reports the full width.
  always_comb begin
    ndigits = ND_W'(1);
    for (int i = 0; i < DIGITS; i++) begin
      if (acc[4*i +: 4] != 4'd0) begin
        ndigits = ND_W'(i + 1);
      end
    end
    if (ovf) begin
      ndigits = ND_W'(DIGITS);
    end
  end

  assign bus.in_ready    = in_ready_c;
  assign bus.out_valid   = out_valid_c;
  assign bus.out_bcd     = acc;
  assign bus.out_neg     = neg;
  assign bus.out_ovf     = ovf;
  assign bus.out_ndigits = ndigits;

endmodule

// File: tb/tb_bin2bcd_stream.sv
// tb/tb_bin2bcd_stream.sv - scoreboard bench for bin2bcd_stream (32b/10d and 8b/2d builds)
module tb_bin2bcd_stream;

  typedef struct {
    logic [39:0] bcd;
    bit          neg;
    int          nd;
    bit          ovf;
  } exp_t;

  logic clk;
  logic rst_n;
  int   cyc;
  int   n_chk;
  int   n_fail;
  int   stall_a;
  bit   manual_a;
  bit   man_ready_a;

  exp_t exp_qa[$];
  exp_t exp_qb[$];
  int   acc_qa[$];
  int   acc_qb[$];

  bin2bcd_stream_if #(.IN_W(32), .DIGITS(10)) bus_a ();
  bin2bcd_stream_if #(.IN_W(8),  .DIGITS(2))  bus_b ();

  bin2bcd_stream #(.IN_W(32), .DIGITS(10), .SIGNED_EN(1)) dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_a)
  );

  bin2bcd_stream #(.IN_W(8), .DIGITS(2), .SIGNED_EN(1)) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference: decimal arithmetic straight from the value.
  function automatic exp_t model(input longint unsigned raw, input int w, input int d, input bit s);
    exp_t e;
    longint unsigned mag, lim, v;
    int n;
    raw   = raw & ((64'd1 << w) - 64'd1);
    e.neg = s && raw[w-1];
    mag   = e.neg ? ((64'd1 << w) - raw) : raw;
    lim   = 1;
    for (int i = 0; i < d; i++) lim = lim * 10;
    e.ovf = (mag >= lim);
    v     = mag;
    e.bcd = '0;
    for (int i = 0; i < d; i++) begin
      e.bcd = e.bcd | (40'(v % 10) << (4 * i));
      v = v / 10;
    end
    n = 1;
    v = mag;
    while (v >= 10) begin
      v = v / 10;
      n++;
    end
    e.nd = e.ovf ? d : n;
    return e;
  endfunction

  task automatic check(input string name, input longint unsigned act, input longint unsigned exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic send_a(input logic [31:0] d, input bit s);
    int n;
    n = 0;
    @(negedge clk);
    while (!bus_a.in_ready && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (!bus_a.in_ready) begin
      check("a_in_ready_timeout", bus_a.in_ready, 1);
      return;
    end
    bus_a.in_data   = d;
    bus_a.in_signed = s;
    bus_a.in_valid  = 1'b1;
    exp_qa.push_back(model(d, 32, 10, s));
    @(negedge clk);
    acc_qa.push_back(cyc);
    bus_a.in_valid  = 1'b0;
    bus_a.in_data   = $urandom;
    bus_a.in_signed = $urandom_range(0, 1);
  endtask

  task automatic send_b(input logic [7:0] d, input bit s);
    int n;
    n = 0;
    @(negedge clk);
    while (!bus_b.in_ready && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (!bus_b.in_ready) begin
      check("b_in_ready_timeout", bus_b.in_ready, 1);
      return;
    end
    bus_b.in_data   = d;
    bus_b.in_signed = s;
    bus_b.in_valid  = 1'b1;
    exp_qb.push_back(model(d, 8, 2, s));
    @(negedge clk);
    acc_qb.push_back(cyc);
    bus_b.in_valid  = 1'b0;
    bus_b.in_data   = 8'($urandom);
    bus_b.in_signed = $urandom_range(0, 1);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_qa.size() != 0 || exp_qb.size() != 0) && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check("drain_pending", exp_qa.size() + exp_qb.size(), 0);
  endtask

  // Result consumers: random backpressure, or a manually scripted ready on A.
  always @(negedge clk) begin
    bus_a.out_ready = manual_a ? man_ready_a : ($urandom_range(0, 3) != 0);
    bus_b.out_ready = ($urandom_range(0, 2) != 0);
  end

  // Monitor A: latency on rising valid, results at handshake, hold while stalled.
  initial begin : mon_a
    exp_t e;
    bit   prev;
    bit   post;
    prev = 0;
    post = 0;
    forever begin
      @(negedge clk);
      #1;
      if (!rst_n) begin
        prev = 0;
        post = 0;
      end else begin
        if (post) begin
          check("a_valid_after_pop", bus_a.out_valid, 0);
          check("a_ready_after_pop", bus_a.in_ready, 1);
          post = 0;
        end
        if (bus_a.out_valid && !prev) begin
          check("a_accept_pending", acc_qa.size() != 0, 1);
          if (acc_qa.size() != 0) check("a_latency", cyc - acc_qa.pop_front(), 32);
        end
        if (bus_a.out_valid) begin
          check("a_result_pending", exp_qa.size() != 0, 1);
          if (exp_qa.size() != 0) begin
            e = exp_qa[0];
            check("a_bcd", bus_a.out_bcd, e.bcd);
            check("a_neg", bus_a.out_neg, e.neg);
            check("a_ndigits", bus_a.out_ndigits, e.nd);
            check("a_ovf", bus_a.out_ovf, e.ovf);
            if (bus_a.out_ready) begin
              void'(exp_qa.pop_front());
              post = 1;
            end else begin
              check("a_stall_in_ready", bus_a.in_ready, 0);
              stall_a++;
            end
          end
        end
        prev = bus_a.out_valid && !bus_a.out_ready;
      end
    end
  end

  // Monitor B: same checks for the narrow overflow-prone build.
  initial begin : mon_b
    exp_t e;
    bit   prev;
    bit   post;
    prev = 0;
    post = 0;
    forever begin
      @(negedge clk);
      #1;
      if (!rst_n) begin
        prev = 0;
        post = 0;
      end else begin
        if (post) begin
          check("b_valid_after_pop", bus_b.out_valid, 0);
          check("b_ready_after_pop", bus_b.in_ready, 1);
          post = 0;
        end
        if (bus_b.out_valid && !prev) begin
          check("b_accept_pending", acc_qb.size() != 0, 1);
          if (acc_qb.size() != 0) check("b_latency", cyc - acc_qb.pop_front(), 8);
        end
        if (bus_b.out_valid) begin
          check("b_result_pending", exp_qb.size() != 0, 1);
          if (exp_qb.size() != 0) begin
            e = exp_qb[0];
            check("b_bcd", bus_b.out_bcd, e.bcd);
            check("b_neg", bus_b.out_neg, e.neg);
            check("b_ndigits", bus_b.out_ndigits, e.nd);
            check("b_ovf", bus_b.out_ovf, e.ovf);
            if (bus_b.out_ready) begin
              void'(exp_qb.pop_front());
              post = 1;
            end else begin
              check("b_stall_in_ready", bus_b.in_ready, 0);
            end
          end
        end
        prev = bus_b.out_valid && !bus_b.out_ready;
      end
    end
  end

  initial begin : watchdog
    #600000;
    $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int   n;
    int   s0;
    logic [31:0] d;
    cyc = 0; n_chk = 0; n_fail = 0; stall_a = 0;
    manual_a = 0; man_ready_a = 0;
    rst_n = 1'b0;
    bus_a.in_valid = 1'b0; bus_a.in_data = '0; bus_a.in_signed = 1'b0;
    bus_b.in_valid = 1'b0; bus_b.in_data = '0; bus_b.in_signed = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_a_in_ready", bus_a.in_ready, 1);
    check("rst_a_out_valid", bus_a.out_valid, 0);
    check("rst_a_out_bcd", bus_a.out_bcd, 0);
    check("rst_a_out_neg", bus_a.out_neg, 0);
    check("rst_a_out_ovf", bus_a.out_ovf, 0);
    check("rst_a_out_ndigits", bus_a.out_ndigits, 1);
    check("rst_b_in_ready", bus_b.in_ready, 1);
    check("rst_b_out_valid", bus_b.out_valid, 0);
    check("rst_b_out_ndigits", bus_b.out_ndigits, 1);
    rst_n = 1'b1;

    fork
      begin
        send_a(32'd12345678, 1'b0);
        send_a(32'hFFFFFFFF, 1'b0);
        send_a(32'hFFFFFFFF, 1'b1);
        send_a(32'h80000000, 1'b1);
        send_a(32'd0, 1'b1);
        send_a(32'd1000000000, 1'b0);
        for (int i = 0; i < 25; i++) begin
          case ($urandom_range(0, 3))
            0: d = $urandom_range(0, 999);
            1: d = $urandom_range(0, 99999999);
            2: d = 32'd0 - $urandom_range(1, 100000);
            default: d = $urandom;
          endcase
          send_a(d, 1'($urandom_range(0, 1)));
        end
      end
      begin
        send_b(8'd255, 1'b0);
        send_b(8'd99, 1'b0);
        send_b(8'd100, 1'b0);
        send_b(8'h80, 1'b1);
        send_b(8'hFF, 1'b1);
        send_b(8'd0, 1'b0);
        for (int i = 0; i < 40; i++) send_b(8'($urandom), 1'($urandom_range(0, 1)));
      end
    join
    drain();

    // Backpressure: hold A's result for at least 10 cycles, then pulse ready.
    manual_a = 1; man_ready_a = 0;
    send_a(32'd305419896, 1'b0);
    n = 0;
    while (!bus_a.out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("bp_out_valid", bus_a.out_valid, 1);
    s0 = stall_a;
    repeat (10) @(negedge clk);
    check("bp_stall_cycles", (stall_a - s0) >= 10, 1);
    @(posedge clk); man_ready_a = 1;
    @(posedge clk); man_ready_a = 0;
    repeat (3) @(negedge clk);
    manual_a = 0;
    drain();

    // Asynchronous reset in the middle of a conversion.
    send_a(32'd424242424, 1'b0);
    repeat (16) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_in_ready", bus_a.in_ready, 1);
    check("midrst_out_valid", bus_a.out_valid, 0);
    check("midrst_out_bcd", bus_a.out_bcd, 0);
    check("midrst_out_neg", bus_a.out_neg, 0);
    check("midrst_out_ovf", bus_a.out_ovf, 0);
    exp_qa.delete();
    acc_qa.delete();
    @(negedge clk);
    rst_n = 1'b1;
    send_a(32'd987654321, 1'b0);
    send_a(32'hFFFFFFFB, 1'b1);
    send_b(8'd42, 1'b0);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/bin2bcd_stream.md
Name: bin2bcd_stream

Overview:
- Parametrised iterative binary-to-BCD converter (shift/add-3) with valid/ready handshakes on input and output.
- Generalises the fixed 32-bit, 8-digit converter: configurable input width and digit count, optional signed (two's-complement) input, overflow detection, significant-digit count, and output hold under backpressure.
- Sits between arithmetic/counter datapaths and the 7-segment display driver.
- Fused add-3 and shift give one input bit per cycle.

Parameters:
IN_W, 32, binary input width (>= 2)
DIGITS, 10, number of BCD output digits (>= 1)
SIGNED_EN, 1, 1 = honour in_signed; 0 = in_signed ignored and input always unsigned
CNT_W, $clog2(IN_W+1), width of the bit counter (derived; do not override)
ND_W, $clog2(DIGITS+1), width of out_ndigits (derived; do not override)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  input word valid
in_ready  out  1  converter can accept a word
in_data  in  IN_W  binary value
in_signed  in  1  treat in_data as two's complement; sampled with in_data
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
out_bcd  out  4*DIGITS  BCD result; digit 0 is at [3:0]
out_neg  out  1  result is negative
out_ndigits  out  ND_W  significant digits, 1..DIGITS (zero gives 1)
out_ovf  out  1  magnitude did not fit in DIGITS digits

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on rst_n.
- Reset values: state=S_IDLE; in_ready=1; out_valid=0; out_bcd=0; out_neg=0; out_ovf=0; counter=0. out_ndigits resolves to 1 from the zero result.
- Reset asserted mid-conversion or while out_valid=1 aborts immediately, drops the pending result, and returns to S_IDLE.
- States: S_IDLE, S_CONV, S_DONE. Encoding is in the package; any illegal encoding goes to S_IDLE.
- S_IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: magnitude register <= |in_data| when SIGNED_EN&&in_signed&&in_data[IN_W-1], else in_data.
  - neg flag <= that same sign condition.
  - BCD accumulator <= 0; ovf <= 0; counter <= IN_W; go to S_CONV.
- Magnitude rules:
  - Magnitude is IN_W bits unsigned.
  - The most negative value (e.g. 0x80000000) gives 2^(IN_W-1) with no special case.
  - -0 cannot occur, so out_neg=1 only for a nonzero result.
- S_CONV, per cycle:
  - Each digit >= 5 gets +3 (4-bit wrap impossible).
  - Then {carry_out, acc} <= {acc, mag[IN_W-1]} and mag shifts left by 1.
  - counter decrements.
  - carry_out=1 sets sticky ovf.
  - When counter==1 this cycle, go to S_DONE.
  - in_ready=0 throughout.
- Latency: exactly IN_W clk edges from the accept edge to out_valid=1. Throughput is one word per IN_W+2 cycles when out_ready=1.
- S_DONE:
  - out_valid=1.
  - out_bcd, out_neg, out_ovf are registered and stable while out_valid=1 && out_ready=0.
  - On out_ready, go to S_IDLE. in_ready=0 in S_DONE, so there is no same-cycle reaccept.
- Overflow result: if out_ovf=1, out_bcd holds the low DIGITS digits of the true value (modulo 10^DIGITS) and out_ndigits=DIGITS.
- out_ndigits: combinational from the result register. It is the index of the highest nonzero digit plus 1, with a minimum of 1.
- in_data and in_signed are don't-care outside the accept cycle.

Decomposition:
- Package bcd_pkg:
  - state enum (S_IDLE, S_CONV, S_DONE);
  - bcd_digit_t (logic [3:0]);
  - constants ADD3_THRESH=4'd5 and ADD3_VAL=4'd3.
- Sub-module bcd_digit_adj: combinational, one digit in, one digit out, applying +3 when the digit is >= 5. Instantiated DIGITS times in a generate loop.
- Counter, sign handling, handshake and ndigits encoder stay in the top level.

Test Plan:
- Unsigned, default params: in_data=32'd12345678, in_signed=0 -> out_bcd=40'h0012345678, out_neg=0, out_ndigits=8, out_ovf=0. out_valid rises exactly 32 edges after accept.
- Full scale: in_data=32'hFFFFFFFF, in_signed=0 -> out_bcd=40'h4294967295, out_ndigits=10. Same input with in_signed=1 -> out_bcd=1, out_neg=1, out_ndigits=1.
- Most negative and zero: 32'h80000000 signed -> out_bcd=40'h2147483648, out_neg=1. Then 32'd0 signed -> out_bcd=0, out_neg=0, out_ndigits=1.
- Overflow, IN_W=8, DIGITS=2: in_data=8'd255 -> out_ovf=1, out_bcd=8'h55, out_ndigits=2. in_data=8'd99 -> out_ovf=0, out_bcd=8'h99.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid -> out_* stable and in_ready=0. Pulse out_ready -> out_valid=0 and in_ready=1 on the next edge.
- Reset mid-operation: assert rst_n=0 at conversion bit 17 -> out_valid=0, in_ready=1, out_bcd=0 with no clock edge needed. After release, a fresh word converts correctly.
